alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 8..64, power of two.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount bits taken from data1[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts a new operation.
REQ-007 data0  input  WIDTH  first operand.
REQ-008 data1  input  WIDTH  second operand / shift amount.
REQ-009 opcode  input  4  operation select.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  WIDTH  result.
REQ-013 flags  output  4  {illegal, div0, carry, zero}.

Function
REQ-014 Opcode map: 0 add, 1 sub, 2 mul, 3 div, 4 gt, 5 eq, 6 lt, 8 and, 9 or, 10 xor, 11 xnor, 12 sll, 13 srl, 14 sra; 7 and 15 illegal.
REQ-015 Handshake: transfer on in_valid&in_ready rising edge; operands and opcode captured into registers, inputs ignored afterward.
REQ-016 States: IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 IDLE->DONE on accept of any single-cycle op (all except mul/div, and div with data1=0); latency 1 cycle.
REQ-018 IDLE->BUSY on accept of mul, or div with data1!=0; BUSY lasts exactly WIDTH cycles, then DONE; latency WIDTH+1.
REQ-019 DONE->IDLE on out_ready; out and flags held stable while out_valid=1 and out_ready=0.
REQ-020 No acceptance in the same cycle as DONE->IDLE; next accept earliest one cycle later.
REQ-021 add/sub: modulo 2^WIDTH; carry = carry-out of add, borrow (data0<data1 unsigned) for sub.
REQ-022 mul: unsigned shift-add, one partial product per BUSY cycle; out = low WIDTH bits of product.
REQ-023 div: unsigned restoring, one quotient bit per BUSY cycle; out = quotient, remainder discarded.
REQ-024 div by zero: out = all ones, div0=1, latency 1.
REQ-025 gt/eq/lt: unsigned compare; out = zero-extended 1 or 0.
REQ-026 Shifts: amount = data1[SHW-1:0]; sra replicates data0[WIDTH-1].
REQ-027 Illegal opcode: out = 0, illegal=1, latency 1.
REQ-028 zero = (out==0) for every op; carry=0 except add/sub; div0, illegal=0 except as stated.

Reset
REQ-029 On rst: state=IDLE, in_ready=1 on the following cycle, out_valid=0, out=0, flags=0, iteration counter=0.
REQ-030 rst during BUSY or DONE aborts the operation; its result never appears on out_valid.
REQ-031 rst has priority over every handshake in the same cycle.

Structure
REQ-032 Package alu_pkg holds opcode constants, state enum (IDLE/BUSY/DONE), flag bit indices.
REQ-033 Sub-module alu_muldiv_iter implements the shared iterative mul/div datapath (accumulator, shift register, counter, done pulse); single-cycle ops stay in alu_multicycle.
REQ-034 Single-cycle result path and iterative path share one output register; no combinational path from inputs to out, flags or out_valid.

Verification
REQ-035 WIDTH=32: add 0xFFFFFFFF+1, out_ready=1 -> out=0, flags zero=1 carry=1, out_valid one cycle after accept.
REQ-036 mul 0x0001_0003*0x0000_0005 -> out=0x0005_000F, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-037 div 100/7 -> out=14; div 5/0 -> out=0xFFFFFFFF, div0=1, latency 1.
REQ-038 sra 0x80000000 by data1=0x24 (amount 4) -> out=0xF8000000; srl same -> 0x08000000.
REQ-039 out_ready held 0 for 10 cycles after result -> out/flags stable, in_ready=0; opcode 7 -> out=0, illegal=1.
REQ-040 rst asserted mid-div (cycle 10 of BUSY) -> IDLE, out_valid never asserted; WIDTH=8 regression repeats REQ-036/037 with latency 9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, control states and flag layout.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_GT   = 4'd4;
   localparam logic [3:0] OP_EQ   = 4'd5;
   localparam logic [3:0] OP_LT   = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_XNOR = 4'd11;
   localparam logic [3:0] OP_SLL  = 4'd12;
   localparam logic [3:0] OP_SRL  = 4'd13;
   localparam logic [3:0] OP_SRA  = 4'd14;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int unsigned FLAG_ZERO    = 0;
   localparam int unsigned FLAG_CARRY   = 1;
   localparam int unsigned FLAG_DIV0    = 2;
   localparam int unsigned FLAG_ILLEGAL = 3;

   function automatic logic [3:0] pack_flags(input logic illegal, input logic div0,
                                              input logic carry, input logic zero);
      logic [3:0] f;
      f               = '0;
      f[FLAG_ILLEGAL] = illegal;
      f[FLAG_DIV0]    = div0;
      f[FLAG_CARRY]   = carry;
      f[FLAG_ZERO]    = zero;
      return f;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
// done pulses during the last step; res is the value that step produces.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic             busy_q, div_q;
   logic [CW-1:0]    cnt_q;
   // acc: product accumulator or partial remainder; sh: multiplier or dividend/quotient;
   // opnd: shifting multiplicand or divisor.
   logic [WIDTH-1:0] acc_q, sh_q, opnd_q;
   logic [WIDTH-1:0] acc_d, sh_d, opnd_d;
   logic [WIDTH:0]   shifted;

   always_comb begin
      shifted = {acc_q, sh_q[WIDTH-1]};
      acc_d   = acc_q;
      sh_d    = sh_q;
      opnd_d  = opnd_q;
      if (div_q) begin
         if (shifted >= {1'b0, opnd_q}) begin
            acc_d = WIDTH'(shifted - {1'b0, opnd_q});
            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = shifted[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (sh_q[0]) begin
            acc_d = acc_q + opnd_q;
         end
         sh_d   = sh_q >> 1;
         opnd_d = opnd_q << 1;
      end
   end

   assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign res  = div_q ? sh_d : acc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         sh_q   <= '0;
         opnd_q <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         div_q  <= is_div;
         cnt_q  <= '0;
         acc_q  <= '0;
         sh_q   <= is_div ? a : b;
         opnd_q <= is_div ? b : a;
      end else if (busy_q) begin
         acc_q  <= acc_d;
         sh_q   <= sh_d;
         opnd_q <= opnd_d;
         cnt_q  <= cnt_q + 1'b1;
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes; single-cycle ops and the iterative
// mul/div engine both land in one registered result/flags stage.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags
);

   state_t           state_q;
   logic [WIDTH-1:0] out_q;
   logic [3:0]       flags_q;

   logic [WIDTH-1:0] sc_res;
   logic [3:0]       sc_flags;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   amt;
   logic             carry, div0, illegal, is_iter;
   logic             accept, start, it_done;
   logic [WIDTH-1:0] it_res;

   always_comb begin
      sum     = {1'b0, data0} + {1'b0, data1};
      amt     = data1[SHW-1:0];
      sc_res  = '0;
      carry   = 1'b0;
      div0    = 1'b0;
      illegal = 1'b0;
      is_iter = 1'b0;
      case (opcode)
         OP_ADD: begin
            sc_res = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_SUB: begin
            sc_res = data0 - data1;
            carry  = data0 < data1;
         end
         OP_MUL: is_iter = 1'b1;
         OP_DIV: begin
            // Divide by zero resolves immediately instead of entering the engine.
            if (data1 == '0) begin
               sc_res = '1;
               div0   = 1'b1;
            end else begin
               is_iter = 1'b1;
            end
         end
         OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, data0 > data1};
         OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, data0 == data1};
         OP_LT:   sc_res = {{(WIDTH-1){1'b0}}, data0 < data1};
         OP_AND:  sc_res = data0 & data1;
         OP_OR:   sc_res = data0 | data1;
         OP_XOR:  sc_res = data0 ^ data1;
         OP_XNOR: sc_res = ~(data0 ^ data1);
         OP_SLL:  sc_res = data0 << amt;
         OP_SRL:  sc_res = data0 >> amt;
         OP_SRA:  sc_res = $unsigned($signed(data0) >>> amt);
         default: illegal = 1'b1;
      endcase
      sc_flags = pack_flags(illegal, div0, carry, sc_res == '0);
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign flags     = flags_q;
   assign accept    = in_valid && in_ready;
   assign start     = accept && is_iter;

   alu_muldiv_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .is_div (opcode == OP_DIV),
      .a      (data0),
      .b      (data1),
      .done   (it_done),
      .res    (it_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         flags_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (is_iter) begin
                     state_q <= BUSY;
                  end else begin
                     state_q <= DONE;
                     out_q   <= sc_res;
                     flags_q <= sc_flags;
                  end
               end
            end
            BUSY: begin
               if (it_done) begin
                  state_q <= DONE;
                  out_q   <= it_res;
                  flags_q <= pack_flags(1'b0, 1'b0, 1'b0, it_res == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
